// File: rtl/number_uart_tx.sv
// rtl/number_uart_tx.sv - snapshot a WIDTH-bit number and stream it as UART frames
//
// Purpose: on an accepted start pulse, copies number_i into a shadow register
// and sends it as WIDTH/8 back-to-back UART frames (8N1), least-significant
// byte first and LSB-first within each byte.
// Optional feature: define NUMBER_UART_TX_PARITY_EN to insert an even-parity
// bit after the data bits (8E1 framing, 11 bit periods per frame).
//
// Ports:
//   clk_i      - system clock, rising edge
//   reset_i    - asynchronous active-high reset
//   start_i    - one-cycle request, sampled only while idle
//   number_i   - value to transmit, captured on an accepted start
//   tx_o       - registered UART line, idles high
//   busy_o     - high while a transmission is in progress
//   done_o     - one-cycle pulse after the final stop bit
//   byte_idx_o - index of the byte currently on the line
module number_uart_tx #(
  parameter int WIDTH   = 256,
  parameter int CLK_DIV = 434
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] number_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       byte_idx_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUDW  = $clog2(CLK_DIV);
  localparam logic [BAUDW-1:0] BAUD_LOAD = BAUDW'(CLK_DIV - 1);
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef NUMBER_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [BAUDW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       bit_end;
  logic       last_byte;
  logic       accept;
  logic [7:0] cur_byte;

  assign bit_end   = (baud_q == '0);
  assign last_byte = (idx_q == LAST_IDX);
  assign accept    = (state_q == S_IDLE) && start_i;
  assign cur_byte  = shadow_q[{idx_q, 3'b000} +: 8];

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
`ifdef NUMBER_UART_TX_PARITY_EN
      S_DATA:   if (bit_end && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
`else
      S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
`endif
      // Frames run back to back: no idle gap between bytes.
      S_STOP:  if (bit_end) state_d = last_byte ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    // Reload on every bit boundary; idle keeps it loaded for the first start bit.
    baud_d = (state_q == S_IDLE || bit_end) ? BAUD_LOAD : baud_q - 1'b1;

    bit_d = bit_q;
    if (state_q == S_START) begin
      bit_d = 3'd0;
    end else if (state_q == S_DATA && bit_end) begin
      bit_d = bit_q + 3'd1;
    end

    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (accept) begin
      idx_d    = '0;
      shadow_d = number_i;
    end else if (state_q == S_STOP && bit_end && !last_byte) begin
      idx_d = idx_q + 1'b1;
    end

    done_d = (state_q == S_STOP) && bit_end && last_byte;
    busy_d = (state_d != S_IDLE);

    // tx is the value for the bit that starts on this edge, so the line is registered.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_d];
`ifdef NUMBER_UART_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      baud_q   <= BAUD_LOAD;
      bit_q    <= 3'd0;
      idx_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign byte_idx_o = 8'(idx_q);

endmodule

// File: doc/number_uart_tx.md
# number_uart_tx

Serial output stage for the BBS random-number path. Consumes the 256-bit value held by the number generator, snapshots it on a start pulse, and streams it out as 32 UART frames (8N1, least-significant byte first, LSB-first within each byte). It sits beside the LED/7-segment display stage, taking the same `number` bus and a debounced one-cycle button flag as its `start`.

## Interface
- `WIDTH`, 256, width of `number` in bits; must be a multiple of 8.
- `CLK_DIV`, 434, clock cycles per UART bit; must be at least 2.
- `clk`, in, 1, system clock; all logic is on its rising edge.
- `reset`, in, 1, asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start`, in, 1, one-cycle request pulse (e.g. a button flag); sampled only when idle.
- `number`, in, WIDTH, value to transmit; sampled only on an accepted start.
- `tx`, out, 1, UART line; idles high.
- `busy`, out, 1, high from the cycle after an accepted start until the final stop bit completes.
- `done`, out, 1, one-cycle pulse when the last frame's stop bit ends.
- `byte_idx`, out, 8, index (0..WIDTH/8-1) of the byte currently on the line.

## Operation
- **States:** IDLE, START, DATA, STOP, plus PARITY when enabled.
- **Accepting a start:** in IDLE, `start`=1 copies `number` into a WIDTH-bit shadow register, clears `byte_idx`, and enters START. The upstream stage may regenerate `number` immediately; the transmission still uses the captured copy.
- **Bit counter:** a baud counter loads CLK_DIV-1 on each state/bit entry and counts down. The bit ends when the counter reaches 0.
- **START:** `tx`=0 for one bit period, then go to DATA.
- **DATA:** send 8 bits of the shadow byte `[8*byte_idx+7 : 8*byte_idx]`, bit 0 first, using a 3-bit bit counter. After bit 7, go to STOP (or PARITY when enabled).
- **STOP:** `tx`=1 for one bit period. Then:
  - if `byte_idx` < WIDTH/8-1: increment `byte_idx` and go straight to START, with no idle gap;
  - otherwise: pulse `done`, clear `busy`, return to IDLE.
- **`start` while busy:** ignored. No queuing, and the shadow register is not updated.
- **`start` on the done cycle:** `busy` is already 0, so the pulse is accepted and a new transmission begins.
- **`byte_idx` width:** the upper bits beyond $clog2(WIDTH/8) read 0.

## Timing
- **Reset values (asynchronous):** `tx`=1, `busy`=0, `done`=0, `byte_idx`=0, state=IDLE, shadow register=0.
- **Start latency:** `start` is sampled at edge N. From edge N, `tx`=0 and `busy`=1, so both are visible in cycle N+1.
- **Output timing:** every line bit lasts exactly CLK_DIV cycles. `tx` is driven from a register, so it is glitch-free.
- **Frame length:** 10·CLK_DIV cycles, or 11·CLK_DIV with parity.
- **Transmission length:** (WIDTH/8)·frame cycles. `done`=1 for exactly one cycle, in the cycle right after the last stop bit. `busy` falls in that same cycle.
- **Reset mid-operation:** all outputs return to their reset values at once (`tx` goes high, possibly truncating a frame). No `done` is emitted. The next start begins again at byte 0.

## Configuration
- **`NUMBER_UART_TX_PARITY_EN` defined:** a PARITY state follows DATA. It sends an even-parity bit (XOR of the 8 data bits) for one bit period, then goes to STOP. Frame length is 11·CLK_DIV.
- **Macro undefined:** no PARITY state and no parity logic; frames are plain 8N1 at 10·CLK_DIV.

## Test plan
All scenarios use CLK_DIV=4 and WIDTH=256.
- **Idle after reset:** pulse reset, then hold for 200 cycles with no start -> `tx`=1, `busy`=0, `done`=0, `byte_idx`=0 throughout.
- **Basic transmission:** `number` low bytes 8'hA5 (byte 0) and 8'h01 (byte 1), start at edge N -> from N, `tx`=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop 4 cycles, then the next start bit immediately. Byte 1 sends 1,0,0,0,0,0,0,0. `done`=1 only at cycle N+1281; `busy`=1 for cycles N+1..N+1280.
- **Snapshot:** change `number` to all-ones 10 cycles after start -> the line still carries the originally captured bytes for all 32 frames.
- **Start while busy / start on done:** `start` pulse at N+500 -> ignored, and `done` stays at N+1281. A second `start` at cycle N+1281 -> `tx` goes low in cycle N+1282 and `byte_idx`=0.
- **Reset mid-frame:** assert reset during byte_idx=3 while `tx`=0 -> `tx`=1 immediately, `busy`=0, no `done`. A following start sends byte 0 first.
- **Parity build (`NUMBER_UART_TX_PARITY_EN`):** bytes 8'hA5 / 8'h01 -> parity bits 0 / 1, frame 44 cycles, `done` at N+1409.
